// File: rtl/adc_window_averager.sv
// adc_window_averager: averages blocks of 2^LOG2_N ADC codes on rising eoc_i
// edges and presents mean/min/max through a single-entry valid/ready register.
//
// Output register states:
//   state   | meaning
//   S_EMPTY | no result held, valid_o = 0
//   S_FULL  | result held, valid_o = 1, waiting for ready_i
module adc_window_averager #(
  parameter int LOG2_N = 4,
  parameter int CODE_W = 12
) (
  input  logic              clk_78MHz_i,
  input  logic              reset_i,
  input  logic              enable_i,
  input  logic [15:0]       data_i,
  input  logic              eoc_i,
  input  logic              ready_i,
  output logic [CODE_W-1:0] avg_o,
  output logic [CODE_W-1:0] min_o,
  output logic [CODE_W-1:0] max_o,
  output logic              valid_o,
  output logic              overrun_o
);

  // A zero-bit counter is not legal, so LOG2_N = 0 keeps a 1-bit counter pinned at 0.
  localparam int CNT_W = (LOG2_N > 0) ? LOG2_N : 1;
  localparam int ACC_W = CODE_W + LOG2_N;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((1 << LOG2_N) - 1);
  localparam logic [CODE_W-1:0] CODE_MAX = {CODE_W{1'b1}};

  localparam logic [0:0] S_EMPTY = 1'b0;
  localparam logic [0:0] S_FULL  = 1'b1;

  logic              r_eoc_q;
  logic [CNT_W-1:0]  r_count;
  logic [ACC_W-1:0]  r_acc;
  logic [CODE_W-1:0] r_min;
  logic [CODE_W-1:0] r_max;
  logic [0:0]        r_state;
  logic [CODE_W-1:0] r_avg;
  logic [CODE_W-1:0] r_min_out;
  logic [CODE_W-1:0] r_max_out;
  logic              r_overrun;

  logic [CODE_W-1:0] w_code;
  logic              w_accept;
  logic              w_final;
  logic [ACC_W-1:0]  w_sum;
  logic [CODE_W-1:0] w_min_next;
  logic [CODE_W-1:0] w_max_next;

  assign w_code     = data_i[15 -: CODE_W];
  assign w_accept   = eoc_i & ~r_eoc_q & enable_i;
  assign w_final    = w_accept & (r_count == LAST_CNT);
  assign w_sum      = r_acc + ACC_W'(w_code);
  assign w_min_next = (w_code < r_min) ? w_code : r_min;
  assign w_max_next = (w_code > r_max) ? w_code : r_max;

  // Edge-detect register runs regardless of enable so re-enabling never fakes an edge.
  always_ff @(posedge clk_78MHz_i or posedge reset_i) begin
    if (reset_i) r_eoc_q <= 1'b0;
    else         r_eoc_q <= eoc_i;
  end

  // Window accumulation; cleared while disabled and after each completed window.
  always_ff @(posedge clk_78MHz_i or posedge reset_i) begin
    if (reset_i) begin
      r_count <= '0;
      r_acc   <= '0;
      r_min   <= CODE_MAX;
      r_max   <= '0;
    end else if (!enable_i || w_final) begin
      r_count <= '0;
      r_acc   <= '0;
      r_min   <= CODE_MAX;
      r_max   <= '0;
    end else if (w_accept) begin
      r_count <= r_count + CNT_W'(1);
      r_acc   <= w_sum;
      r_min   <= w_min_next;
      r_max   <= w_max_next;
    end
  end

  // Result register: a new result always wins; losing an untaken one sets overrun.
  always_ff @(posedge clk_78MHz_i or posedge reset_i) begin
    if (reset_i) begin
      r_state   <= S_EMPTY;
      r_avg     <= '0;
      r_min_out <= '0;
      r_max_out <= '0;
      r_overrun <= 1'b0;
    end else if (w_final) begin
      r_state   <= S_FULL;
      r_avg     <= w_sum[ACC_W-1 -: CODE_W];
      r_min_out <= w_min_next;
      r_max_out <= w_max_next;
      if (r_state == S_FULL && !ready_i) r_overrun <= 1'b1;
    end else if (r_state == S_FULL && ready_i) begin
      r_state <= S_EMPTY;
    end
  end

  assign avg_o     = r_avg;
  assign min_o     = r_min_out;
  assign max_o     = r_max_out;
  assign valid_o   = (r_state == S_FULL);
  assign overrun_o = r_overrun;

endmodule

// File: tb/tb_adc_window_averager.sv
// Directed bench for adc_window_averager with 4-sample windows, plus a
// single-sample-window instance sharing the same stimulus.
module tb_adc_window_averager;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [15:0] data;
  logic        eoc;
  logic        rdy;
  logic [11:0] avg, mn, mx;
  logic        vld, ovr;
  logic [11:0] avg0, mn0, mx0;
  logic        vld0, ovr0;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  adc_window_averager #(.LOG2_N(2), .CODE_W(12)) u_dut (
    .clk_78MHz_i(clk), .reset_i(rst), .enable_i(en), .data_i(data),
    .eoc_i(eoc), .ready_i(rdy), .avg_o(avg), .min_o(mn), .max_o(mx),
    .valid_o(vld), .overrun_o(ovr));

  adc_window_averager #(.LOG2_N(0), .CODE_W(12)) u_dut0 (
    .clk_78MHz_i(clk), .reset_i(rst), .enable_i(en), .data_i(data),
    .eoc_i(eoc), .ready_i(rdy), .avg_o(avg0), .min_o(mn0), .max_o(mx0),
    .valid_o(vld0), .overrun_o(ovr0));

  typedef struct {
    logic [3:0][11:0] codes;
    logic [11:0]      e_avg;
    logic [11:0]      e_min;
    logic [11:0]      e_max;
  } win_t;

  win_t tbl[5];

  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One-cycle eoc pulse; returns on the falling edge right after the accept edge.
  task automatic send(input logic [11:0] code);
    @(negedge clk);
    data = {code, 4'h0};
    eoc  = 1'b1;
    @(negedge clk);
    eoc  = 1'b0;
  endtask

  task automatic chk_out(input string name, input logic [11:0] a, input logic [11:0] lo,
                         input logic [11:0] hi);
    chk({name, "_valid"}, {11'd0, vld}, 12'd1);
    chk({name, "_avg"}, avg, a);
    chk({name, "_min"}, mn, lo);
    chk({name, "_max"}, mx, hi);
  endtask

  initial begin
    tbl[0] = '{codes: {12'h400, 12'h300, 12'h200, 12'h100}, e_avg: 12'h280, e_min: 12'h100, e_max: 12'h400};
    tbl[1] = '{codes: {12'h002, 12'h001, 12'h001, 12'h001}, e_avg: 12'h001, e_min: 12'h001, e_max: 12'h002};
    tbl[2] = '{codes: {12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF}, e_avg: 12'hFFF, e_min: 12'hFFF, e_max: 12'hFFF};
    tbl[3] = '{codes: {12'h000, 12'h000, 12'h000, 12'h000}, e_avg: 12'h000, e_min: 12'h000, e_max: 12'h000};
    tbl[4] = '{codes: {12'h00A, 12'h009, 12'h008, 12'h007}, e_avg: 12'h008, e_min: 12'h007, e_max: 12'h00A};

    rst = 1'b1; en = 1'b1; data = '0; eoc = 1'b0; rdy = 1'b1;
    #1;
    chk("reset_avg", avg, 12'h000);
    chk("reset_min", mn, 12'h000);
    chk("reset_max", mx, 12'h000);
    chk("reset_valid", {11'd0, vld}, 12'd0);
    chk("reset_overrun", {11'd0, ovr}, 12'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // Table-driven windows with ready held high
    for (int w = 0; w < 5; w++) begin
      for (int s = 0; s < 4; s++) begin
        if (s == 3) chk($sformatf("win%0d_not_early", w), {11'd0, vld}, 12'd0);
        send(tbl[w].codes[s]);
      end
      chk_out($sformatf("win%0d", w), tbl[w].e_avg, tbl[w].e_min, tbl[w].e_max);
      chk($sformatf("win%0d_n1_avg", w), avg0, tbl[w].codes[3]);
      chk($sformatf("win%0d_n1_min", w), mn0, tbl[w].codes[3]);
      chk($sformatf("win%0d_n1_max", w), mx0, tbl[w].codes[3]);
      @(negedge clk);
      chk($sformatf("win%0d_valid_drop", w), {11'd0, vld}, 12'd0);
      chk($sformatf("win%0d_overrun", w), {11'd0, ovr}, 12'd0);
    end

    // Overrun: two windows with ready low
    rdy = 1'b0;
    for (int s = 0; s < 4; s++) send(12'h010);
    chk_out("ovr_w1", 12'h010, 12'h010, 12'h010);
    chk("ovr_w1_flag", {11'd0, ovr}, 12'd0);
    send(12'h020); send(12'h020);
    chk("ovr_hold_avg", avg, 12'h010);
    chk("ovr_hold_valid", {11'd0, vld}, 12'd1);
    send(12'h020); send(12'h020);
    chk_out("ovr_w2", 12'h020, 12'h020, 12'h020);
    chk("ovr_w2_flag", {11'd0, ovr}, 12'd1);
    rdy = 1'b1;
    @(negedge clk);
    rdy = 1'b0;
    chk("ovr_taken_valid", {11'd0, vld}, 12'd0);
    chk("ovr_sticky", {11'd0, ovr}, 12'd1);

    // Level-held eoc counts once
    rdy = 1'b1;
    @(negedge clk);
    data = {12'h800, 4'h0};
    eoc  = 1'b1;
    repeat (6) @(negedge clk);
    eoc  = 1'b0;
    send(12'h000); send(12'h000);
    chk("level_not_early", {11'd0, vld}, 12'd0);
    send(12'h000);
    chk_out("level", 12'h200, 12'h000, 12'h800);
    @(negedge clk);

    // Disable clears the partial window
    send(12'h100); send(12'h100);
    @(negedge clk);
    en = 1'b0;
    repeat (3) @(negedge clk);
    en = 1'b1;
    for (int s = 0; s < 3; s++) send(12'h300);
    chk("enable_not_early", {11'd0, vld}, 12'd0);
    send(12'h300);
    chk_out("enable", 12'h300, 12'h300, 12'h300);
    @(negedge clk);

    // Asynchronous reset mid-window with a pending result
    rdy = 1'b0;
    for (int s = 0; s < 4; s++) send(12'h010);
    for (int s = 0; s < 3; s++) send(12'h777);
    chk("prerst_valid", {11'd0, vld}, 12'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_valid", {11'd0, vld}, 12'd0);
    chk("async_rst_avg", avg, 12'h000);
    chk("async_rst_min", mn, 12'h000);
    chk("async_rst_max", mx, 12'h000);
    chk("async_rst_overrun", {11'd0, ovr}, 12'd0);
    @(negedge clk);
    rst = 1'b0;
    rdy = 1'b1;
    for (int s = 0; s < 3; s++) send(12'h040);
    chk("postrst_not_early", {11'd0, vld}, 12'd0);
    send(12'h040);
    chk_out("postrst", 12'h040, 12'h040, 12'h040);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
